ei_generator: RTL and testbench
===============================

EI_GENERATOR -- requirements
Module: ei_generator

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning the enable period in clock cycles while running (legal range 1..255).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  level request to enter RUN; sampled each rising edge.
REQ-005 SHALL have port stop  input  1  level request to leave RUN; sampled each rising edge.
REQ-006 SHALL have port step  input  1  single-step request; its rising edge is detected internally.
REQ-007 SHALL have port ei  output  1  one-cycle enable pulse that drives the ei input of the least-significant counter digit.
REQ-008 SHALL have port running  output  1  high while in RUN.

Function
REQ-009 SHALL implement the FSM states IDLE, RUN and STEP, plus an 8-bit prescaler presc counting 0..DIV-1.
REQ-010 ei and running SHALL be Moore outputs decoded from registered state only, with no combinational path from any input.
REQ-011 IDLE with start=1 and stop=0 at edge t SHALL enter RUN at t+1, with presc=0.
REQ-012 In RUN, presc SHALL increment each cycle and wrap from DIV-1 to 0.
REQ-013 ei SHALL equal 1 exactly when state=RUN and presc=DIV-1, so the first pulse occurs DIV cycles after RUN entry and then every DIV cycles.
REQ-014 With DIV=1, ei SHALL stay high every cycle in RUN.
REQ-015 RUN with stop=1 at edge t SHALL enter IDLE at t+1 with presc=0; a pulse already visible during cycle t completes.
REQ-016 start and stop high in the same cycle SHALL resolve as stop wins: IDLE stays IDLE, RUN goes to IDLE.
REQ-017 start while in RUN SHALL be ignored, and SHALL NOT restart presc.
REQ-018 A step rising edge (step=1, previous sample 0) seen in IDLE at edge t SHALL enter STEP at t+1; STEP SHALL drive ei=1 for exactly one cycle and return to IDLE at t+2.
REQ-019 A step held high SHALL produce only one pulse; a new pulse requires step to drop to 0 and rise again.
REQ-020 step SHALL be ignored in RUN and in STEP.
REQ-021 start, stop and step edges arriving during STEP SHALL be ignored; their edges are consumed by the internal sampler.
REQ-022 The step previous-sample register SHALL update every cycle in every state.
REQ-023 running SHALL equal 1 exactly when state=RUN, and SHALL be 0 in STEP.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=IDLE, presc=0 and step previous-sample=1, so that a step held through reset does not pulse.
REQ-025 Reset SHALL take priority over start, stop and step in the same cycle.
REQ-026 Reset asserted mid-RUN or in STEP SHALL make ei=0 and running=0 from the next cycle onward.
REQ-027 Following the reset cycle, ei=0 and running=0 SHALL hold until a start or step is accepted.

Configuration
REQ-028 The macro EI_GENERATOR_STEP_EN SHALL control single-step support.
REQ-029 When EI_GENERATOR_STEP_EN is defined, the STEP state and the step edge detector SHALL be compiled in, with behaviour per REQ-018..REQ-022.
REQ-030 When EI_GENERATOR_STEP_EN is undefined, step SHALL be ignored, STEP SHALL be unreachable, the edge register SHALL be omitted, and ei SHALL pulse only in RUN.

Verification
REQ-031 Bench SHALL cover: reset then 10 idle cycles with all inputs 0 -> ei=0 and running=0 throughout.
REQ-032 Bench SHALL cover: DIV=4, start pulse at cycle 0 -> running=1 from cycle 1, ei=1 at cycles 4, 8 and 12 only.
REQ-033 Bench SHALL cover: DIV=4 running, stop at cycle 6 -> running=0 at cycle 7, and no ei after cycle 4.
REQ-034 Bench SHALL cover: start and stop both high in IDLE for 3 cycles -> stays IDLE, ei=0.
REQ-035 Bench SHALL cover: STEP_EN defined, step held high 5 cycles from cycle 2 -> exactly one ei pulse, at cycle 3; repeated with STEP_EN undefined -> no pulse.
REQ-036 Bench SHALL cover: DIV=3 running, reset at presc=2 -> ei=0 and running=0 next cycle, and the next start yields its first pulse 3 cycles later.

Source files
------------

// File: rtl/ei_generator.sv
// ei_generator: enable-pulse source for the least-significant counter digit.
// Params: DIV (enable period while running, 1..255).
// Ports: clock, reset (sync, active-high), start/stop (level requests),
//        step (single-step request, rising edge), ei (one-cycle enable),
//        running (high while in RUN).
// Macro EI_GENERATOR_STEP_EN compiles in the STEP state and step edge detector.
module ei_generator #(
   parameter int unsigned DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic stop,
   input  logic step,
   output logic ei,
   output logic running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(DIV - 1);

   state_t     state;
   logic [7:0] presc;
   logic [7:0] presc_nxt;
   logic       step_rise;

   assign presc_nxt = (presc == LAST) ? 8'd0 : presc + 8'd1;

`ifdef EI_GENERATOR_STEP_EN
   // Resets to 1 so a step held through reset is not taken as an edge.
   logic step_q;

   always_ff @(posedge clock) begin
      if (reset) step_q <= 1'b1;
      else       step_q <= step;
   end

   assign step_rise = step & ~step_q;
`else
   logic unused_step;

   assign unused_step = step;
   assign step_rise   = 1'b0;
`endif

   // Outputs are registered alongside the state so that at all times
   // ei == (RUN && presc == LAST) || STEP and running == RUN.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= 8'd0;
         ei      <= 1'b0;
         running <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!stop && start) begin
                  state   <= RUN;
                  presc   <= 8'd0;
                  ei      <= (LAST == 8'd0);
                  running <= 1'b1;
               end else if (!stop && step_rise) begin
                  state   <= STEP;
                  ei      <= 1'b1;
                  running <= 1'b0;
               end else begin
                  ei      <= 1'b0;
                  running <= 1'b0;
               end
            end
            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  presc   <= 8'd0;
                  ei      <= 1'b0;
                  running <= 1'b0;
               end else begin
                  presc   <= presc_nxt;
                  ei      <= (presc_nxt == LAST);
                  running <= 1'b1;
               end
            end
            STEP: begin
               state   <= IDLE;
               ei      <= 1'b0;
               running <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               presc   <= 8'd0;
               ei      <= 1'b0;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ei_generator.sv
// tb_ei_generator: directed vectors for ei_generator at DIV=4, 3 and 1.
// Expectations follow EI_GENERATOR_STEP_EN as defined for the build.
module tb_ei_generator;

`ifdef EI_GENERATOR_STEP_EN
   localparam bit SE = 1'b1;
`else
   localparam bit SE = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst4 = 1'b1, start4 = 1'b0, stop4 = 1'b0, step4 = 1'b0;
   logic rst3 = 1'b1, start3 = 1'b0, stop3 = 1'b0, step3 = 1'b0;
   logic rst1 = 1'b1, start1 = 1'b0, stop1 = 1'b0, step1 = 1'b0;
   logic ei4, run4, ei3, run3, ei1, run1;

   ei_generator #(.DIV(4)) u4 (
      .clock(clock), .reset(rst4), .start(start4), .stop(stop4),
      .step(step4), .ei(ei4), .running(run4)
   );

   ei_generator #(.DIV(3)) u3 (
      .clock(clock), .reset(rst3), .start(start3), .stop(stop3),
      .step(step3), .ei(ei3), .running(run3)
   );

   ei_generator #(.DIV(1)) u1 (
      .clock(clock), .reset(rst1), .start(start1), .stop(stop1),
      .step(step1), .ei(ei1), .running(run1)
   );

   typedef struct {
      logic rst, start, stop, step;
      logic ei_s, run_s, ei_n, run_n;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int idx,
                      input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input int n, input logic rst, start, stop, step,
                      input logic ei_s, run_s, ei_n, run_n);
      vec_t v;
      v.rst = rst; v.start = start; v.stop = stop; v.step = step;
      v.ei_s = ei_s; v.run_s = run_s; v.ei_n = ei_n; v.run_n = run_n;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   task automatic addb(input int n, input logic rst, start, stop, step,
                       input logic ei, run);
      add(n, rst, start, stop, step, ei, run, ei, run);
   endtask

   initial begin
      // idle after reset
      addb(10, 0,0,0,0, 0,0);
      // DIV=4 start at c0: pulses at c4, c8, c12; start at c6 ignored
      addb(1, 0,1,0,0, 0,0);
      addb(3, 0,0,0,0, 0,1);
      addb(1, 0,0,0,0, 1,1);
      addb(1, 0,0,0,0, 0,1);
      addb(1, 0,1,0,0, 0,1);
      addb(1, 0,0,0,0, 0,1);
      addb(1, 0,0,0,0, 1,1);
      addb(3, 0,0,0,0, 0,1);
      addb(1, 0,0,0,0, 1,1);
      addb(1, 0,0,1,0, 0,1);
      addb(1, 0,0,0,0, 0,0);
      // stop at c6
      addb(1, 0,1,0,0, 0,0);
      addb(3, 0,0,0,0, 0,1);
      addb(1, 0,0,0,0, 1,1);
      addb(1, 0,0,0,0, 0,1);
      addb(1, 0,0,1,0, 0,1);
      addb(2, 0,0,0,0, 0,0);
      // stop during the pulse cycle: pulse completes
      addb(1, 0,1,0,0, 0,0);
      addb(3, 0,0,0,0, 0,1);
      addb(1, 0,0,1,0, 1,1);
      addb(1, 0,0,0,0, 0,0);
      // start+stop together: idle stays, run leaves
      addb(3, 0,1,1,0, 0,0);
      addb(1, 0,0,0,0, 0,0);
      addb(1, 0,1,0,0, 0,0);
      addb(1, 0,1,1,0, 0,1);
      addb(1, 0,0,0,0, 0,0);
      // step held 5 cycles from c2
      addb(2, 0,0,0,0, 0,0);
      addb(1, 0,0,0,1, 0,0);
      add (1, 0,0,0,1, 1,0, 0,0);
      addb(3, 0,0,0,1, 0,0);
      addb(2, 0,0,0,0, 0,0);
      // second step after release
      addb(1, 0,0,0,1, 0,0);
      add (1, 0,0,0,0, 1,0, 0,0);
      addb(1, 0,0,0,0, 0,0);
      // step edges in RUN ignored
      addb(1, 0,1,0,0, 0,0);
      addb(1, 0,0,0,1, 0,1);
      addb(1, 0,0,0,0, 0,1);
      addb(1, 0,0,0,1, 0,1);
      addb(1, 0,0,1,1, 1,1);
      addb(1, 0,0,0,1, 0,0);
      addb(1, 0,0,0,0, 0,0);
      // start during STEP ignored
      addb(1, 0,0,0,1, 0,0);
      add (1, 0,1,0,0, 1,0, 0,0);
      add (1, 0,0,1,0, 0,0, 0,1);
      addb(1, 0,0,0,0, 0,0);
      // reset beats start; step held through reset gives no pulse
      addb(1, 1,1,0,0, 0,0);
      addb(1, 1,0,0,1, 0,0);
      addb(2, 0,0,0,1, 0,0);
      addb(2, 0,0,0,0, 0,0);
      // reset mid-RUN
      addb(1, 0,1,0,0, 0,0);
      addb(1, 0,0,0,0, 0,1);
      addb(1, 1,1,0,0, 0,1);
      addb(1, 0,0,0,0, 0,0);

      cyc();
      rst4 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;
      chk("reset_ei4", 0, ei4, 1'b0);
      chk("reset_run4", 0, run4, 1'b0);
      chk("reset_ei1", 0, ei1, 1'b0);
      chk("reset_run1", 0, run1, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst4 = tbl[i].rst; start4 = tbl[i].start;
         stop4 = tbl[i].stop; step4 = tbl[i].step;
         chk("tbl_ei", i, ei4, SE ? tbl[i].ei_s : tbl[i].ei_n);
         chk("tbl_run", i, run4, SE ? tbl[i].run_s : tbl[i].run_n);
         cyc();
      end
      rst4 = 1'b0; start4 = 1'b0; stop4 = 1'b0; step4 = 1'b0;

      // DIV=3: reset at presc=2, then restart
      start3 = 1'b1;
      chk("d3_idle_run", 0, run3, 1'b0);
      cyc(); start3 = 1'b0;
      chk("d3_p0_run", 0, run3, 1'b1);
      chk("d3_p0_ei", 0, ei3, 1'b0);
      cyc();
      chk("d3_p1_ei", 0, ei3, 1'b0);
      cyc();
      chk("d3_p2_ei", 0, ei3, 1'b1);
      rst3 = 1'b1;
      cyc(); rst3 = 1'b0;
      chk("d3_rst_ei", 0, ei3, 1'b0);
      chk("d3_rst_run", 0, run3, 1'b0);
      cyc();
      chk("d3_hold_ei", 0, ei3, 1'b0);
      chk("d3_hold_run", 0, run3, 1'b0);
      start3 = 1'b1;
      cyc(); start3 = 1'b0;
      chk("d3_re_run", 0, run3, 1'b1);
      chk("d3_re_p0", 0, ei3, 1'b0);
      cyc();
      chk("d3_re_p1", 0, ei3, 1'b0);
      cyc();
      chk("d3_re_p2", 0, ei3, 1'b1);
      cyc();
      chk("d3_re_wrap", 0, ei3, 1'b0);
      chk("d3_re_wrap_run", 0, run3, 1'b1);
      stop3 = 1'b1;
      cyc(); stop3 = 1'b0;
      chk("d3_stop_run", 0, run3, 1'b0);
      // reset during STEP
      step3 = 1'b1;
      cyc();
      chk("d3_step_ei", 0, ei3, SE);
      chk("d3_step_run", 0, run3, 1'b0);
      rst3 = 1'b1;
      cyc(); rst3 = 1'b0; step3 = 1'b0;
      chk("d3_steprst_ei", 0, ei3, 1'b0);
      cyc();
      chk("d3_steprst_ei2", 0, ei3, 1'b0);

      // DIV=1: ei high every RUN cycle
      start1 = 1'b1;
      cyc(); start1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("d1_ei", i, ei1, 1'b1);
         chk("d1_run", i, run1, 1'b1);
         cyc();
      end
      stop1 = 1'b1;
      chk("d1_last_ei", 0, ei1, 1'b1);
      cyc(); stop1 = 1'b0;
      chk("d1_stop_ei", 0, ei1, 1'b0);
      chk("d1_stop_run", 0, run1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
